uart_rx: RTL and testbench

Serial UART receiver that converts the asynchronous `i_rx` line into parallel bytes. It is the receive-side counterpart to the baud clock source and shares its runtime 24-bit divisor format (`i_div_num` = system clocks per bit). It sits between the device pin and the RX FIFO/register interface of the UART IP. Frame format is 8N1: one start bit, 8 data bits LSB first, no parity, one stop bit. Bit timing is derived internally from `i_div_num`, with mid-bit sampling.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with a runtime 24-bit divisor (clocks per
//            bit), 2-flop input synchronizer and mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int DIV_MIN   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [23:0]          i_div_num,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam logic [23:0] c_div_min  = 24'(DIV_MIN);
  localparam logic [2:0]  c_last_idx = 3'(DATA_BITS - 1);

  state_t                 r_state;
  logic                   r_ff1;
  logic                   r_ff2;
  logic [23:0]            r_cnt;
  logic [23:0]            r_div;
  logic [2:0]             r_idx;
  logic [DATA_BITS-1:0]   r_shift;

  logic [23:0]            w_div_clamped;
  logic [23:0]            w_half;
  logic [23:0]            w_last;

  // Divisor clamp applied at latch time; half and last-count derived from the latched copy
  assign w_div_clamped = (i_div_num < c_div_min) ? c_div_min : i_div_num;
  assign w_half        = r_div >> 1;
  assign w_last        = r_div - 24'd1;
  assign o_busy        = (r_state != S_IDLE);

  // Two-flop synchronizer for the asynchronous line; idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
    end else begin
      r_ff1 <= i_rx;
      r_ff2 <= r_ff1;
    end
  end

  // Frame state machine with registered data and single-cycle status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 24'd0;
      r_div       <= c_div_min;
      r_idx       <= 3'd0;
      r_shift     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_ff2) begin
            r_state <= S_START;
            r_cnt   <= 24'd0;
            r_div   <= w_div_clamped;
          end
        end
        S_START: begin
          if (r_cnt == w_half) begin
            if (r_ff2) begin
              // Line went back high before mid start bit: glitch, not a frame
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= 24'd0;
              r_idx   <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == w_last) begin
            r_shift[r_idx] <= r_ff2;
            r_cnt          <= 24'd0;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == c_last_idx) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_STOP: begin
          if (r_cnt == w_last) begin
            r_cnt <= 24'd0;
            if (r_ff2) begin
              o_data  <= r_shift;
              o_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it cannot look like a stream of starts
          if (r_ff2) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx. Frames are scheduled at the
//            bit level; the expected pulse edge, data and busy window of each
//            frame are computed from the frame timing equations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIG = 32'h7fff_ffff;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] i_div_num;
  logic        i_rx;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;

  uart_rx #(.DATA_BITS(8), .DIV_MIN(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_div_num   (i_div_num),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         e;
    bit         v;
    logic [7:0] d;
  } ev_t;

  ev_t        ev_q[$];
  int         bs[$];
  int         be[$];
  int         obs_e[$];
  logic [7:0] obs_d[$];

  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         busy_cycles = 0;
  int         err_pulses = 0;
  logic [7:0] model_data = 8'h00;

  int   cur_e;
  logic rs_smp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Per-cycle compare against the scheduled expectations
  always @(posedge clock) begin
    cur_e  = edge_cnt;
    rs_smp = reset;
    edge_cnt++;
    #1;
    begin
      bit   exp_v;
      bit   exp_f;
      bit   exp_b;
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      if (rs_smp) model_data = 8'h00;
      while (ev_q.size() != 0 && ev_q[0].e < cur_e) begin
        chk("missed_event_edge", 32'(cur_e), 32'(ev_q[0].e));
        void'(ev_q.pop_front());
      end
      if (ev_q.size() != 0 && ev_q[0].e == cur_e) begin
        exp_v = ev_q[0].v;
        exp_f = !ev_q[0].v;
        if (ev_q[0].v) model_data = ev_q[0].d;
        void'(ev_q.pop_front());
      end
      for (int i = 0; i < bs.size(); i++)
        if (cur_e >= bs[i] && cur_e < be[i]) exp_b = 1'b1;
      if (!rs_smp || cur_e > 0) begin
        chk("o_valid", 32'(o_valid), 32'(exp_v));
        chk("o_frame_err", 32'(o_frame_err), 32'(exp_f));
        chk("o_data", 32'(o_data), 32'(model_data));
        chk("o_busy", 32'(o_busy), 32'(exp_b));
      end
      if (o_valid) begin
        obs_e.push_back(cur_e);
        obs_d.push_back(o_data);
      end
      if (o_busy) busy_cycles++;
      if (o_frame_err) err_pulses++;
    end
  end

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Drive one frame at bit period max(div,4); optionally change the divisor
  // input at bit chg_bit, or pulse reset at frame-relative edge abort_at.
  task automatic send_frame(input logic [7:0] b, input int div, input bit good_stop,
                            input int chg_bit, input int chg_val, input int abort_at,
                            output int e0);
    int d, h, stop_e;
    i_div_num = div[23:0];
    d = (div < 4) ? 4 : div;
    h = d >> 1;
    e0 = edge_cnt;
    stop_e = e0 + 3 + h + 9 * d;
    if (abort_at > 0) begin
      bs.push_back(e0 + 2);
      be.push_back(e0 + abort_at);
    end else begin
      ev_q.push_back('{stop_e, good_stop, good_stop ? b : 8'h00});
      bs.push_back(e0 + 2);
      be.push_back(good_stop ? stop_e : BIG);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == chg_bit) i_div_num = chg_val[23:0];
      i_rx = (i == 0) ? 1'b0 : (i == 9) ? good_stop : b[i-1];
      for (int j = 0; j < d; j++) begin
        reset = (abort_at > 0 && edge_cnt == e0 + abort_at);
        if (abort_at > 0 && edge_cnt == e0 + abort_at + 1) begin
          chk("rst_o_data", 32'(o_data), 32'h00);
          chk("rst_o_busy", 32'(o_busy), 32'h0);
          chk("rst_o_valid", 32'(o_valid), 32'h0);
        end
        @(negedge clock);
      end
    end
    reset = 1'b0;
  endtask

  // Release a held-low line; busy stays up until the synchronizer shows high
  task automatic release_break(input bit lit);
    int r;
    r = edge_cnt;
    be[be.size()-1] = r + 2;
    i_rx = 1'b1;
    @(negedge clock);
    @(negedge clock);
    if (lit) chk("break_busy_hold", 32'(o_busy), 32'h1);
    @(negedge clock);
    if (lit) chk("break_busy_drop", 32'(o_busy), 32'h0);
  endtask

  initial begin
    int e0, ea, n0, div, gap;
    logic [7:0] b;
    reset = 1'b1;
    i_rx = 1'b1;
    i_div_num = 24'd16;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_o_data", 32'(o_data), 32'h00);
    chk("reset_o_valid", 32'(o_valid), 32'h0);
    chk("reset_o_frame_err", 32'(o_frame_err), 32'h0);
    chk("reset_o_busy", 32'(o_busy), 32'h0);
    idle(20);

    // Basic byte
    n0 = obs_e.size();
    send_frame(8'hA5, 16, 1'b1, -1, 0, 0, e0);
    idle(20);
    chk("basic_count", 32'(obs_e.size() - n0), 32'd1);
    if (obs_e.size() > n0) begin
      chk("basic_edge", 32'(obs_e[n0] - e0), 32'd155);
      chk("basic_data", 32'(obs_d[n0]), 32'hA5);
    end

    // Back-to-back
    n0 = obs_e.size();
    send_frame(8'h00, 16, 1'b1, -1, 0, 0, e0);
    send_frame(8'hFF, 16, 1'b1, -1, 0, 0, e0);
    send_frame(8'h3C, 16, 1'b1, -1, 0, 0, e0);
    idle(20);
    chk("b2b_count", 32'(obs_e.size() - n0), 32'd3);
    if (obs_e.size() >= n0 + 3) begin
      chk("b2b_gap1", 32'(obs_e[n0+1] - obs_e[n0]), 32'd160);
      chk("b2b_gap2", 32'(obs_e[n0+2] - obs_e[n0+1]), 32'd160);
      chk("b2b_d0", 32'(obs_d[n0]), 32'h00);
      chk("b2b_d1", 32'(obs_d[n0+1]), 32'hFF);
      chk("b2b_d2", 32'(obs_d[n0+2]), 32'h3C);
    end

    // False start
    n0 = obs_e.size();
    e0 = edge_cnt;
    bs.push_back(e0 + 2);
    be.push_back(e0 + 11);
    busy_cycles = 0;
    i_rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(40);
    chk("false_busy_cycles", 32'(busy_cycles), 32'd9);
    chk("false_no_valid", 32'(obs_e.size() - n0), 32'd0);

    // Frame error then break
    err_pulses = 0;
    send_frame(8'h55, 16, 1'b0, -1, 0, 0, e0);
    repeat (100) @(negedge clock);
    release_break(1'b1);
    idle(20);
    chk("break_err_pulses", 32'(err_pulses), 32'd1);
    chk("break_data_kept", 32'(o_data), 32'h3C);
    n0 = obs_e.size();
    send_frame(8'h81, 16, 1'b1, -1, 0, 0, e0);
    idle(20);
    chk("after_break_data", 32'(o_data), 32'h81);
    chk("after_break_count", 32'(obs_e.size() - n0), 32'd1);

    // Divisor clamp and mid-frame divisor change
    send_frame(8'h96, 1, 1'b1, -1, 0, 0, e0);
    idle(20);
    chk("clamp_data", 32'(o_data), 32'h96);
    send_frame(8'hC3, 16, 1'b1, 4, 8, 0, e0);
    idle(20);
    chk("divchg_data", 32'(o_data), 32'hC3);

    // Reset mid-frame, then a clean frame
    n0 = obs_e.size();
    send_frame(8'hFF, 16, 1'b1, -1, 0, 60, ea);
    idle(20);
    chk("abort_no_valid", 32'(obs_e.size() - n0), 32'd0);
    send_frame(8'h3C, 16, 1'b1, -1, 0, 0, e0);
    idle(20);
    chk("post_reset_data", 32'(o_data), 32'h3C);

    // Randomized frames, divisors and gaps, with occasional breaks
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      div = $urandom_range(0, 24);
      gap = $urandom_range(4, 40);
      if ($urandom_range(0, 7) == 0) begin
        send_frame(b, div, 1'b0, -1, 0, 0, e0);
        repeat ($urandom_range(0, 30)) @(negedge clock);
        release_break(1'b0);
      end else begin
        send_frame(b, div, 1'b1, -1, 0, 0, e0);
      end
      idle(gap);
    end
    idle(50);
    chk("pending_events", 32'(ev_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
